// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
// through one registered carry, with a start/done handshake and carry-out/overflow flags.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   psum;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic [DIGIT:0]     dig;
    logic [WIDTH+DIGIT-1:0] cat;
    logic               msb_cin;

    assign dig  = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
    // New digit enters from the MSB end; the low DIGIT bits drop off.
    assign cat  = {dig[DIGIT-1:0], psum};
    // On the final digit, the top sum bit reveals the carry that flowed into it.
    assign msb_cin = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ dig[DIGIT-1];
    assign last = (cnt == '0);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= x;
            b_reg <= y;
            carry <= cin;
            cnt   <= CW'(N - 1);
        end else if (state == RUN) begin
            a_reg <= a_reg >> DIGIT;
            b_reg <= b_reg >> DIGIT;
            carry <= dig[DIGIT];
            psum  <= cat[WIDTH+DIGIT-1:DIGIT];
            cnt   <= cnt - 1'b1;
            if (last) begin
                sum  <= cat[WIDTH+DIGIT-1:DIGIT];
                cout <= dig[DIGIT];
                ovf  <= msb_cin ^ dig[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (8/1, 8/4, 4/1, 4/2) driven from a directed
// vector table, hand-written handshake sequences, and exhaustive 4-bit sweeps.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       st [4];
    logic [7:0] xa [4];
    logic [7:0] ya [4];
    logic       ci [4];
    logic       bz [4];
    logic       dn [4];
    logic [7:0] sm [4];
    logic       co [4];
    logic       ov [4];
    logic [7:0] s0, s1;
    logic [3:0] s2, s3;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .x(xa[0]), .y(ya[0]),
        .cin(ci[0]), .busy(bz[0]), .done(dn[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .x(xa[1]), .y(ya[1]),
        .cin(ci[1]), .busy(bz[1]), .done(dn[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .x(xa[2][3:0]),
        .y(ya[2][3:0]), .cin(ci[2]), .busy(bz[2]), .done(dn[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .x(xa[3][3:0]),
        .y(ya[3][3:0]), .cin(ci[3]), .busy(bz[3]), .done(dn[3]), .sum(s3), .cout(co[3]), .ovf(ov[3]));

    assign sm[0] = s0;
    assign sm[1] = s1;
    assign sm[2] = {4'b0, s2};
    assign sm[3] = {4'b0, s3};

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         u;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl [10];

    function automatic int ncyc(input int u);
        case (u)
            0: return 8;
            1: return 2;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int wid(input int u);
        return (u < 2) ? 8 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full add on instance u: checks busy for N cycles, then the done cycle and result.
    task automatic do_add(input int u, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo, input logic full);
        int n;
        n = ncyc(u);
        @(negedge clk);
        st[u] = 1'b1; xa[u] = a; ya[u] = b; ci[u] = c;
        @(negedge clk);
        st[u] = 1'b0; xa[u] = 8'h00; ya[u] = 8'h00; ci[u] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (full) begin
                chk($sformatf("busy u%0d cyc%0d", u, i), {31'b0, bz[u]}, 32'd1);
                chk($sformatf("done_low u%0d cyc%0d", u, i), {31'b0, dn[u]}, 32'd0);
            end
            if (i < n - 1) @(negedge clk);
        end
        @(negedge clk);
        chk($sformatf("done u%0d %h+%h+%b", u, a, b, c), {30'b0, dn[u], bz[u]}, 32'd2);
        chk($sformatf("sum u%0d %h+%h+%b", u, a, b, c), {24'b0, sm[u]}, {24'b0, es});
        chk($sformatf("cout/ovf u%0d %h+%h+%b", u, a, b, c), {30'b0, co[u], ov[u]}, {30'b0, ec, eo});
        @(negedge clk);
        if (full) chk($sformatf("done_drop u%0d", u), {30'b0, dn[u], bz[u]}, 32'd0);
    endtask

    initial begin
        int cnt_done;
        logic [7:0] got;
        logic [7:0] bb_a [3];
        logic [7:0] bb_b [3];
        logic       bb_c [3];
        logic [7:0] bb_s [3];
        logic       bb_co [3];
        logic       bb_ov [3];

        tbl[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5] = '{2, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b1};
        tbl[6] = '{2, 8'h0F, 8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[7] = '{3, 8'h08, 8'h08, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[8] = '{3, 8'h05, 8'h0A, 1'b0, 8'h0F, 1'b0, 1'b0};
        tbl[9] = '{0, 8'h55, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0};

        bb_a = '{8'hA5, 8'h12, 8'h70};
        bb_b = '{8'h5A, 8'h34, 8'h70};
        bb_c = '{1'b1, 1'b0, 1'b0};
        bb_s = '{8'h00, 8'h46, 8'hE0};
        bb_co = '{1'b1, 1'b0, 1'b0};
        bb_ov = '{1'b0, 1'b0, 1'b1};

        for (int u = 0; u < 4; u++) begin
            st[u] = 1'b0; xa[u] = 8'h00; ya[u] = 8'h00; ci[u] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset busy/done u%0d", u), {30'b0, bz[u], dn[u]}, 32'd0);
            chk($sformatf("reset sum/cout/ovf u%0d", u), {22'b0, sm[u], co[u], ov[u]}, 32'd0);
        end

        for (int i = 0; i < 10; i++)
            do_add(tbl[i].u, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);

        // Back-to-back adds on the DIGIT=4 instance with start held high.
        @(negedge clk);
        st[1] = 1'b1; xa[1] = bb_a[0]; ya[1] = bb_b[0]; ci[1] = bb_c[0];
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk($sformatf("b2b busy0 r%0d", r), {30'b0, bz[1], dn[1]}, 32'd2);
            if (r < 2) begin
                xa[1] = bb_a[r+1]; ya[1] = bb_b[r+1]; ci[1] = bb_c[r+1];
            end else begin
                st[1] = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b2b busy1 r%0d", r), {30'b0, bz[1], dn[1]}, 32'd2);
            @(negedge clk);
            chk($sformatf("b2b done r%0d", r), {30'b0, bz[1], dn[1]}, 32'd1);
            chk($sformatf("b2b result r%0d", r), {22'b0, sm[1], co[1], ov[1]},
                {22'b0, bb_s[r], bb_co[r], bb_ov[r]});
        end
        @(negedge clk);
        chk("b2b idle", {30'b0, bz[1], dn[1]}, 32'd0);

        // A start pulse during RUN must be ignored.
        @(negedge clk);
        st[0] = 1'b1; xa[0] = 8'h03; ya[0] = 8'h04; ci[0] = 1'b0;
        cnt_done = 0;
        got = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dn[0]) begin
                cnt_done++;
                got = sm[0];
            end
            st[0] = (i == 1);
            xa[0] = (i == 1) ? 8'h11 : 8'h00;
            ya[0] = (i == 1) ? 8'h11 : 8'h00;
        end
        chk("ignored start done count", cnt_done, 32'd1);
        chk("ignored start sum", {24'b0, got}, 32'h07);
        chk("ignored start idle", {30'b0, bz[0], dn[0]}, 32'd0);

        // Exhaustive 4-bit sweeps against the arithmetic reference.
        for (int u = 2; u < 4; u++) begin
            for (int k = 0; k < 512; k++) begin
                logic [3:0] a, b;
                logic c;
                logic [4:0] t;
                logic eo;
                a = k[3:0]; b = k[7:4]; c = k[8];
                t = {1'b0, a} + {1'b0, b} + {4'b0, c};
                eo = (a[3] == b[3]) && (t[3] != a[3]);
                do_add(u, {4'b0, a}, {4'b0, b}, c, {4'b0, t[3:0]}, t[4], eo, 1'b0);
            end
        end

        // Reset in the middle of an add on u0, after a known non-zero result.
        do_add(0, 8'h55, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        st[0] = 1'b1; xa[0] = 8'hFF; ya[0] = 8'hFF; ci[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset busy", {31'b0, bz[0]}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid-run reset busy/done", {30'b0, bz[0], dn[0]}, 32'd0);
        chk("mid-run reset sum/cout/ovf", {22'b0, sm[0], co[0], ov[0]}, 32'd0);
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dn[0] || bz[0]) cnt_done++;
        end
        chk("no done after reset", cnt_done, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
